uart_cmd_rx: RTL

Receive side of the team's UART command link, the counterpart to the command transmitter. Samples the serial rx line and decodes 11-bit frames: start, 8 data bits LSB first, parity, stop. Pairs two consecutive good bytes into one CMD_WIDTH command word, high byte first. Presents the word on a valid/ready handshake to the command decoder.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_byte_rx.sv | 155 +++++++++++++++
 rtl/uart_cmd_rx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command receive path.
package uart_pkg;

   // Receiver frame FSM states
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // Frame layout: start + 8 data + parity + stop
   localparam int DATA_BITS  = 8;
   localparam int FRAME_BITS = 11;

   // Clock cycles per serial bit period
   function automatic int bit_cyc(input int clk_freq, input int br);
      return clk_freq / br;
   endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Byte-level UART receiver: rx synchronizer, start-edge detect, frame FSM,
// and odd-parity / stop-bit checks. Outcome pulses are registered one cycle
// after the stop-bit sample.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int BIT_CYC = 434,
   parameter bit CHEAK   = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] byte_data_o,
   output logic       byte_vld_o,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       start_edge_o,
   output logic       idle_o
);

   localparam int CNT_W = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CYC / 2 - 1);
   localparam logic [3:0]       LAST_BIT = 4'(DATA_BITS - 1);

   logic             rx_s1_q, rx_s2_q, rx_d1_q;
   logic             start_edge;
   rx_state_t        state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [3:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic [7:0]       byte_data_q, byte_data_d;
   logic             byte_vld_q, byte_vld_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             tick;

   // Two-flop synchronizer plus a delay flop for edge detection; held at the
   // idle level during reset so line activity then cannot fake a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_d1_q <= 1'b1;
      end else begin
         rx_s1_q <= rx_i;
         rx_s2_q <= rx_s1_q;
         rx_d1_q <= rx_s2_q;
      end
   end

   assign start_edge = rx_d1_q & ~rx_s2_q;
   assign tick       = (baud_q == FULL_M1);

   // Frame FSM next-state, bit sampling and outcome classification
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      par_d       = par_q;
      byte_data_d = byte_data_q;
      byte_vld_d  = 1'b0;
      perr_d      = 1'b0;
      ferr_d      = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (start_edge) begin
               state_d = START;
               bit_d   = '0;
            end
         end
         START: begin
            if (baud_q == HALF_M1) begin
               baud_d  = '0;
               // A line already back high at mid-bit is a glitch, not a start
               state_d = rx_s2_q ? IDLE : DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (tick) begin
               baud_d  = '0;
               shift_d = {rx_s2_q, shift_q[7:1]};
               bit_d   = bit_q + 4'd1;
               if (bit_q == LAST_BIT) state_d = PARITY;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         PARITY: begin
            if (tick) begin
               baud_d  = '0;
               par_d   = rx_s2_q;
               state_d = STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (tick) begin
               baud_d  = '0;
               state_d = IDLE;
               if (!rx_s2_q) begin
                  ferr_d = 1'b1;
               end else if (CHEAK && (par_q != ~^shift_q)) begin
                  perr_d = 1'b1;
               end else begin
                  byte_vld_d  = 1'b1;
                  byte_data_d = shift_q;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM, counters, shift register and registered outcome pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         byte_data_q <= '0;
         byte_vld_q  <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         byte_data_q <= byte_data_d;
         byte_vld_q  <= byte_vld_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
      end
   end

   assign byte_data_o  = byte_data_q;
   assign byte_vld_o   = byte_vld_q;
   assign parity_err_o = perr_q;
   assign frame_err_o  = ferr_q;
   assign start_edge_o = start_edge;
   assign idle_o       = (state_q == IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: pairs consecutive good bytes (high byte first) into
// a command word and offers it on a valid/ready handshake. A stalled
// partial word is dropped after an inter-byte gap timeout.
module uart_cmd_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BR        = 115200,
   parameter int CMD_WIDTH = 16,
   parameter bit CHEAK     = 1'b1,
   parameter int GAP_BITS  = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [CMD_WIDTH-1:0] cmd_out,
   output logic                 cmd_out_vld,
   input  logic                 cmd_out_rdy,
   output logic [7:0]           byte_data,
   output logic                 byte_vld,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int BIT_CYC = bit_cyc(CLK_FREQ, BR);
   localparam int GAP_LIM = GAP_BITS * BIT_CYC;
   localparam int GAP_W   = $clog2(GAP_LIM + 1);
   localparam logic [GAP_W-1:0] GAP_END = GAP_W'(GAP_LIM);

   logic [7:0]           rx_byte;
   logic                 rx_vld, rx_perr, rx_ferr, rx_start, rx_idle;
   logic                 half_q, half_d;
   logic [7:0]           hi_q, hi_d;
   logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
   logic                 cmd_vld_q, cmd_vld_d;
   logic                 ovr_q, ovr_d;
   logic [GAP_W-1:0]     gap_q, gap_d;

   uart_byte_rx #(
      .BIT_CYC (BIT_CYC),
      .CHEAK   (CHEAK)
   ) u_byte (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (rx),
      .byte_data_o  (rx_byte),
      .byte_vld_o   (rx_vld),
      .parity_err_o (rx_perr),
      .frame_err_o  (rx_ferr),
      .start_edge_o (rx_start),
      .idle_o       (rx_idle)
   );

   // Word assembly, gap timeout and output handshake next-state
   always_comb begin
      half_d    = half_q;
      hi_d      = hi_q;
      cmd_d     = cmd_q;
      cmd_vld_d = cmd_vld_q;
      ovr_d     = 1'b0;
      gap_d     = gap_q;

      if (cmd_vld_q && cmd_out_rdy) cmd_vld_d = 1'b0;

      if (rx_start) begin
         gap_d = '0;
      end else if (half_q && rx_idle) begin
         if (gap_q == GAP_END) begin
            gap_d  = '0;
            half_d = 1'b0;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end else if (!half_q) begin
         gap_d = '0;
      end

      if (rx_perr || rx_ferr) begin
         half_d = 1'b0;
      end else if (rx_vld) begin
         if (!half_q) begin
            hi_d   = rx_byte;
            half_d = 1'b1;
         end else begin
            half_d = 1'b0;
            // The slot frees up this cycle if the current word is being taken
            if (!cmd_vld_q || cmd_out_rdy) begin
               cmd_d     = CMD_WIDTH'({hi_q, rx_byte});
               cmd_vld_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end
      end
   end

   // Assembler, gap timer and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         half_q    <= 1'b0;
         hi_q      <= '0;
         cmd_q     <= '0;
         cmd_vld_q <= 1'b0;
         ovr_q     <= 1'b0;
         gap_q     <= '0;
      end else begin
         half_q    <= half_d;
         hi_q      <= hi_d;
         cmd_q     <= cmd_d;
         cmd_vld_q <= cmd_vld_d;
         ovr_q     <= ovr_d;
         gap_q     <= gap_d;
      end
   end

   assign cmd_out     = cmd_q;
   assign cmd_out_vld = cmd_vld_q;
   assign byte_data   = rx_byte;
   assign byte_vld    = rx_vld;
   assign parity_err  = rx_perr;
   assign frame_err   = rx_ferr;
   assign overrun     = ovr_q;

endmodule
